// File: rtl/lc3_pkg.sv
// LC-3 subset core: opcodes, memory-access states, pipeline control encodings.
package lc3_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h3000;

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE;

  // psr bit positions
  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;

  typedef enum logic [1:0] {
    READ     = 2'd0,
    READ_IND = 2'd1,
    WRITE    = 2'd2,
    IDLE     = 2'd3
  } mem_state_t;

  // Where the Execute result goes at writeback
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM} wb_sel_t;

  // Kind of data-memory access the Execute instruction needs
  typedef enum logic [2:0] {MC_NONE, MC_LD, MC_LDI, MC_ST, MC_STI} mem_ctl_t;

  typedef struct packed {
    logic       branch;  // BR or JMP
    logic [2:0] dr;
  } e_ctl_t;

  // Condition code of a value written to the register file
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    logic [2:0] f;
    f = '0;
    if (v[15])        f[PSR_N] = 1'b1;
    else if (v == '0) f[PSR_Z] = 1'b1;
    else              f[PSR_P] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/lc3_if.sv
// Instruction and data memory bus of the LC-3 core.
interface lc3_if;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        Data_rd;

  modport master (
    output pc, instrmem_rd, Data_addr, Data_din, Data_rd,
    input  Instr_dout, complete_instr, complete_data, Data_dout
  );

  modport slave (
    input  pc, instrmem_rd, Data_addr, Data_din, Data_rd,
    output Instr_dout, complete_instr, complete_data, Data_dout
  );
endinterface

// File: rtl/lc3_regfile.sv
// 8x16 register file with two async read ports, one write port and psr.
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [15:0] d1,
  output logic [15:0] d2,
  output logic [2:0]  psr
);

  logic [15:0] rf [8];

  // Register and condition-code update on every register write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      psr <= 3'b010;
    end else if (we) begin
      rf[wa] <= wd;
      psr    <= nzp_of(wd);
    end
  end

  assign d1 = rf[ra1];
  assign d2 = rf[ra2];

endmodule

// File: rtl/lc3_core.sv
// Pipelined LC-3 subset core: Fetch / Decode / Execute / Writeback plus a
// data-memory state machine. Decode reads operands and computes ALU and
// address results, which are latched into the Execute registers.
// Build option: LC3_BYPASS_EN enables result forwarding; without it the
// controller interlocks Fetch/Decode on RAW dependences instead.
module lc3_core
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
)(
  input logic   clock,
  input logic   reset,
  lc3_if.master bus
);

  // [1] Decode valid, [2] Execute valid
  logic [2:1]  vld_pipe;
  logic        f_vld;

  logic [15:0] pc_r, npc_out, IR, e_npc;
  logic [15:0] aluout, pcout, M_Data, mem_ptr, memout;
  logic [2:0]  NZP, psr;
  e_ctl_t      E_Control;
  wb_sel_t     W_Control;
  mem_ctl_t    Mem_Control;
  mem_state_t  mem_state, mem_nxt;

  logic enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
  logic br_taken, redirect, stall, hazard, mem_done;
  logic bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;

  // Decode fields
  logic [3:0]  op;
  logic [2:0]  sr1, sr2;
  logic        use1, use2, is_store, is_branch, e_wr_alu;
  logic [15:0] d1, d2, op1, op2, opb, alu_d, pc_d;
  logic [2:0]  nzp_d;
  wb_sel_t     wb_d;
  mem_ctl_t    mc_d;
  logic [15:0] rf_wd;

  assign op        = IR[15:12];
  assign sr1       = IR[8:6];
  assign is_store  = (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  assign sr2       = is_store ? IR[11:9] : IR[2:0];
  assign use1      = op inside {OP_ADD, OP_AND, OP_NOT, OP_JMP, OP_LDR, OP_STR};
  assign use2      = ((op == OP_ADD || op == OP_AND) && !IR[5]) || is_store;
  assign is_branch = (op == OP_BR) || (op == OP_JMP);
  assign e_wr_alu  = vld_pipe[2] && (W_Control == WB_ALU);
  assign memout    = bus.Data_dout;

  lc3_regfile u_rf (
    .clock (clock),
    .reset (reset),
    .we    (enable_writeback),
    .wa    (E_Control.dr),
    .wd    (rf_wd),
    .ra1   (sr1),
    .ra2   (sr2),
    .d1    (d1),
    .d2    (d2),
    .psr   (psr)
  );

  // Forwarding (bypass build) or RAW interlock (default build)
  always_comb begin
    bypass_alu_1 = 1'b0;
    bypass_alu_2 = 1'b0;
    bypass_mem_1 = 1'b0;
    bypass_mem_2 = 1'b0;
    hazard       = 1'b0;
`ifdef LC3_BYPASS_EN
    bypass_alu_1 = e_wr_alu && use1 && (E_Control.dr == sr1);
    bypass_alu_2 = e_wr_alu && use2 && (E_Control.dr == sr2);
    bypass_mem_1 = (mem_state == READ) && use1 && (E_Control.dr == sr1);
    bypass_mem_2 = (mem_state == READ) && use2 && (E_Control.dr == sr2);
`else
    hazard = vld_pipe[1] && e_wr_alu &&
             ((use1 && (E_Control.dr == sr1)) || (use2 && (E_Control.dr == sr2)));
`endif
  end

  // Operand select, ALU, address generation and control decode
  always_comb begin
    op1 = bypass_alu_1 ? aluout : (bypass_mem_1 ? memout : d1);
    op2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? memout : d2);
    opb = IR[5] ? {{11{IR[4]}}, IR[4:0]} : op2;
    pc_d = npc_out + {{7{IR[8]}}, IR[8:0]};
    case (op)
      OP_LDR, OP_STR: pc_d = op1 + {{10{IR[5]}}, IR[5:0]};
      OP_JMP:         pc_d = op1;
      default:        ;
    endcase
    case (op)
      OP_ADD:  alu_d = op1 + opb;
      OP_AND:  alu_d = op1 & opb;
      OP_NOT:  alu_d = ~op1;
      OP_LEA:  alu_d = pc_d;
      default: alu_d = '0;
    endcase
    nzp_d = (op == OP_BR) ? IR[11:9] : ((op == OP_JMP) ? 3'b111 : 3'b000);
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LEA: wb_d = WB_ALU;
      OP_LD, OP_LDR, OP_LDI:          wb_d = WB_MEM;
      default:                        wb_d = WB_NONE;
    endcase
    case (op)
      OP_LD, OP_LDR: mc_d = MC_LD;
      OP_LDI:        mc_d = MC_LDI;
      OP_ST, OP_STR: mc_d = MC_ST;
      OP_STI:        mc_d = MC_STI;
      default:       mc_d = MC_NONE;
    endcase
  end

  // Pipeline controller: memory activity or a data-side wait freezes the pipe
  always_comb begin
    stall           = !bus.complete_data || (mem_state != IDLE);
    enable_execute  = !stall;
    enable_decode   = !stall && !hazard;
    enable_fetch    = enable_decode;
    enable_updatePC = enable_fetch && bus.complete_instr && !(vld_pipe[1] && is_branch);
    // word fetched behind a branch in Decode or Execute is dropped
    f_vld    = bus.complete_instr && !(vld_pipe[1] && is_branch) &&
               !(vld_pipe[2] && E_Control.branch);
    br_taken = vld_pipe[2] && E_Control.branch && |(NZP & psr);
    redirect = vld_pipe[2] && E_Control.branch && enable_execute;
    mem_done = ((mem_state == READ) || (mem_state == WRITE)) && bus.complete_data;
    enable_writeback = (e_wr_alu && enable_execute) ||
                       ((mem_state == READ) && bus.complete_data);
    rf_wd    = (mem_state == READ) ? memout : aluout;
  end

  assign bus.pc          = pc_r;
  assign bus.instrmem_rd = enable_fetch;

  // Program counter: branch redirect has priority over sequential fetch
  always_ff @(posedge clock) begin
    if (reset)                pc_r <= RESET_PC;
    else if (redirect)        pc_r <= br_taken ? pcout : e_npc;
    else if (enable_updatePC) pc_r <= pc_r + 16'd1;
  end

  // Decode register
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      IR          <= '0;
      npc_out     <= '0;
    end else if (enable_decode) begin
      vld_pipe[1] <= f_vld;
      IR          <= bus.Instr_dout;
      npc_out     <= pc_r + 16'd1;
    end
  end

  // Execute registers; a finished memory op retires out of Execute
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe[2] <= 1'b0;
      aluout      <= '0;
      pcout       <= '0;
      M_Data      <= '0;
      NZP         <= '0;
      e_npc       <= '0;
      E_Control   <= '0;
      W_Control   <= WB_NONE;
      Mem_Control <= MC_NONE;
    end else if (enable_execute) begin
      vld_pipe[2] <= vld_pipe[1] && !hazard;
      aluout      <= alu_d;
      pcout       <= pc_d;
      M_Data      <= op2;
      NZP         <= nzp_d;
      e_npc       <= npc_out;
      E_Control   <= '{branch: is_branch, dr: IR[11:9]};
      W_Control   <= wb_d;
      Mem_Control <= mc_d;
    end else if (mem_done) begin
      vld_pipe[2] <= 1'b0;
    end
  end

  // Memory state register; a data-side wait holds the state
  always_ff @(posedge clock) begin
    if (reset)                  mem_state <= IDLE;
    else if (bus.complete_data) mem_state <= mem_nxt;
  end

  // Indirect pointer captured at the end of READ_IND
  always_ff @(posedge clock) begin
    if (reset)                                            mem_ptr <= '0;
    else if ((mem_state == READ_IND) && bus.complete_data) mem_ptr <= bus.Data_dout;
  end

  // Memory next state: start when a memory op enters Execute
  always_comb begin
    mem_nxt = mem_state;
    case (mem_state)
      IDLE:
        if (enable_execute && vld_pipe[1] && !hazard) begin
          case (mc_d)
            MC_LD:          mem_nxt = READ;
            MC_LDI, MC_STI: mem_nxt = READ_IND;
            MC_ST:          mem_nxt = WRITE;
            default:        mem_nxt = IDLE;
          endcase
        end
      READ_IND: mem_nxt = (Mem_Control == MC_LDI) ? READ : WRITE;
      default:  mem_nxt = IDLE;
    endcase
  end

  // Memory bus outputs per state
  always_comb begin
    bus.Data_addr = '0;
    bus.Data_din  = '0;
    bus.Data_rd   = 1'b1;
    case (mem_state)
      READ_IND: bus.Data_addr = pcout;
      READ:     bus.Data_addr = (Mem_Control == MC_LDI) ? mem_ptr : pcout;
      WRITE: begin
        bus.Data_addr = (Mem_Control == MC_STI) ? mem_ptr : pcout;
        bus.Data_din  = M_Data;
        bus.Data_rd   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_core.sv
// Directed tests for lc3_core: reset, ALU/flags, RAW chain, LD, STI, branches.
module tb_lc3_core;

  logic clock = 1'b0;
  logic reset;

  lc3_if bus();

  lc3_core #(.RESET_PC(16'h3000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] imem [256];
  logic [15:0] dmem [65536];

  assign bus.Instr_dout = imem[bus.pc[7:0]];
  assign bus.Data_dout  = dmem[bus.Data_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clr_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hD000;  // reserved opcode: NOP
  endtask

  task automatic restart();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) dmem[i] = '0;
    dmem[16'h3003] = 16'h8000;
    dmem[16'h3004] = 16'h4000;
    bus.complete_instr = 1'b1;
    bus.complete_data  = 1'b1;

    // Reset state and free-running fetch
    clr_imem();
    reset = 1'b1;
    step(2);
    chk("rst_pc",    bus.pc, 16'h3000);
    chk("rst_irdd",  16'(bus.instrmem_rd), 16'd1);
    chk("rst_drd",   16'(bus.Data_rd), 16'd1);
    chk("rst_daddr", bus.Data_addr, 16'h0000);
    chk("rst_ddin",  bus.Data_din, 16'h0000);
    chk("rst_psr",   16'(dut.psr), 16'b010);
    chk("rst_mst",   16'(dut.mem_state), 16'd3);
    reset = 1'b0;
    step(1); chk("pc1", bus.pc, 16'h3001);
    step(1); chk("pc2", bus.pc, 16'h3002);
    bus.complete_instr = 1'b0;
    step(1); chk("pc_frz", bus.pc, 16'h3002);
    bus.complete_instr = 1'b1;
    step(1); chk("pc3", bus.pc, 16'h3003);

    // ADD R1,R0,#5 ; AND R2,R2,#0
    clr_imem();
    imem[0] = 16'h1225;
    imem[1] = 16'h54A0;
    restart();
    step(3);
    chk("add_r1",  dut.u_rf.rf[1], 16'd5);
    chk("add_psr", 16'(dut.psr), 16'b001);
    step(1);
    chk("and_r2",  dut.u_rf.rf[2], 16'd0);
    chk("and_psr", 16'(dut.psr), 16'b010);

    // RAW chain: ADD R1,R0,#1 ; ADD R2,R1,#1
    clr_imem();
    imem[0] = 16'h1221;
    imem[1] = 16'h1461;
    restart();
    step(2);
`ifdef LC3_BYPASS_EN
    chk("raw_byp", 16'(dut.bypass_alu_1), 16'd1);
`else
    chk("raw_byp", 16'(dut.bypass_alu_1), 16'd0);
`endif
    step(1);
    chk("raw_r1", dut.u_rf.rf[1], 16'd1);
    step(1);
`ifdef LC3_BYPASS_EN
    chk("raw_r2_early", dut.u_rf.rf[2], 16'd2);
`else
    chk("raw_r2_early", dut.u_rf.rf[2], 16'd0);
`endif
    step(1);
    chk("raw_r2", dut.u_rf.rf[2], 16'd2);

    // LD R3,#2 at 0x3000 -> address 0x3003
    clr_imem();
    imem[0] = 16'h2602;
    restart();
    step(2);
    chk("ld_addr", bus.Data_addr, 16'h3003);
    chk("ld_rd",   16'(bus.Data_rd), 16'd1);
    chk("ld_mst",  16'(dut.mem_state), 16'd0);
    chk("ld_hold", 16'(bus.instrmem_rd), 16'd0);
    step(1);
    chk("ld_r3",   dut.u_rf.rf[3], 16'h8000);
    chk("ld_psr",  16'(dut.psr), 16'b100);
    chk("ld_idle", 16'(dut.mem_state), 16'd3);
    chk("ld_pc",   bus.pc, 16'h3002);

    // ADD R1,R0,#5 ; NOP ; STI R1,#1 (pointer at 0x3004 = 0x4000)
    clr_imem();
    imem[0] = 16'h1225;
    imem[2] = 16'hB201;
    restart();
    step(4);
    chk("sti_ind_mst",  16'(dut.mem_state), 16'd1);
    chk("sti_ind_addr", bus.Data_addr, 16'h3004);
    chk("sti_ind_rd",   16'(bus.Data_rd), 16'd1);
    step(1);
    chk("sti_wr_mst",  16'(dut.mem_state), 16'd2);
    chk("sti_wr_addr", bus.Data_addr, 16'h4000);
    chk("sti_wr_rd",   16'(bus.Data_rd), 16'd0);
    chk("sti_wr_din",  bus.Data_din, 16'd5);
    step(1);
    chk("sti_idle", 16'(dut.mem_state), 16'd3);
    chk("sti_rd1",  16'(bus.Data_rd), 16'd1);

    // BRz #4 with psr = Z: taken to 0x3005
    clr_imem();
    imem[0] = 16'h0404;
    imem[1] = 16'h1827;  // ADD R4,R0,#7 (shadow, must not execute)
    imem[5] = 16'h1A23;  // ADD R5,R0,#3
    restart();
    step(2);
    chk("brz_taken", 16'(dut.br_taken), 16'd1);
    chk("brz_pc_hold", bus.pc, 16'h3001);
    step(1);
    chk("brz_pc", bus.pc, 16'h3005);
    step(3);
    chk("brz_r5", dut.u_rf.rf[5], 16'd3);
    chk("brz_r4", dut.u_rf.rf[4], 16'd0);

    // BRn #4 with psr = Z: falls through to 0x3001
    clr_imem();
    imem[0] = 16'h0804;
    imem[1] = 16'h1827;
    imem[5] = 16'h1A23;
    restart();
    step(2);
    chk("brn_taken", 16'(dut.br_taken), 16'd0);
    step(1);
    chk("brn_pc", bus.pc, 16'h3001);
    step(3);
    chk("brn_r4", dut.u_rf.rf[4], 16'd7);
    chk("brn_r5", dut.u_rf.rf[5], 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
